// File: rtl/ifu_fetch_sequencer_pkg.sv
// Shared codes for the fetch sequencer: next-PC source selects, FSM states
// and default watchdog sizing.
package ifu_fetch_sequencer_pkg;

   localparam int DEF_WAIT_W   = 4;
   localparam int DEF_MAX_WAIT = 15;

   typedef enum logic [1:0] {
      NPC_PC4 = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_e;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/ifu_fetch_sequencer_if.sv
// Decode-side control-transfer inputs, instruction memory handshake and PC
// register controls of the fetch sequencer.
interface ifu_fetch_sequencer_if;

   logic       stall;
   logic       redirect_valid;
   logic [1:0] npc_mode;
   logic       is_conditional;
   logic       condition;
   logic       imem_ack;
   logic       imem_req;
   logic       pc_we;
   logic [1:0] pc_sel;
   logic       if_valid;
   logic       fetch_timeout;
   logic       redirect_overlap;

   // master drives the decode/memory side, slave is the sequencer itself
   modport master (
      output stall, redirect_valid, npc_mode, is_conditional, condition, imem_ack,
      input  imem_req, pc_we, pc_sel, if_valid, fetch_timeout, redirect_overlap
   );

   modport slave (
      input  stall, redirect_valid, npc_mode, is_conditional, condition, imem_ack,
      output imem_req, pc_we, pc_sel, if_valid, fetch_timeout, redirect_overlap
   );

endinterface

// File: rtl/ifu_fetch_sequencer_watchdog.sv
// Saturating fetch-wait counter; raises a sticky flag once a single fetch
// has waited MAX_WAIT cycles without an acknowledge.
module ifu_fetch_sequencer_watchdog #(
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_timeout
);

   localparam logic [WAIT_W-1:0] LP_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] LP_SAT = '1;

   logic [WAIT_W-1:0] r_cnt;
   logic [WAIT_W-1:0] w_cntNext;
   logic              r_timeout;

   always_comb begin
      w_cntNext = r_cnt;
      if (i_clear) begin
         w_cntNext = '0;
      end else if (i_inc && (r_cnt != LP_SAT)) begin
         w_cntNext = r_cnt + 1'b1;
      end
   end

   // Flag is taken from the next count so it appears together with the count reaching MAX_WAIT
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt <= w_cntNext;
         if (i_inc && (w_cntNext == LP_MAX)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_timeout = r_timeout;

endmodule

// File: rtl/ifu_fetch_sequencer.sv
// Fetch sequencer: decides each cycle whether the PC advances and from which
// source, applying taken transfers after exactly one delay slot.
module ifu_fetch_sequencer
   import ifu_fetch_sequencer_pkg::*;
#(
   parameter int WAIT_W   = DEF_WAIT_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic                 clk,
   input  logic                 reset,
   ifu_fetch_sequencer_if.slave bus
);

   state_e   r_state;
   state_e   w_stateNext;
   logic     r_pendValid;
   npc_sel_e r_pendSel;
   logic     r_overlap;

   npc_sel_e w_mode;
   logic     w_taken;
   logic     w_accept;
   logic     w_imemReq;
   logic     w_pcWe;
   logic     w_ifValid;
   npc_sel_e w_pcSel;
   logic     w_wdClear;
   logic     w_wdInc;
   logic     w_timeout;

   assign w_mode   = npc_sel_e'(bus.npc_mode);
   assign w_taken  = bus.redirect_valid & (w_mode != NPC_PC4) &
                     (~bus.is_conditional | bus.condition);
   assign w_accept = w_taken & ~bus.stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_BOOT:  w_stateNext = S_FETCH;
         S_FETCH: if (bus.imem_ack && bus.stall) w_stateNext = S_HOLD;
         S_HOLD:  if (!bus.stall) w_stateNext = S_FETCH;
         default: w_stateNext = S_BOOT;
      endcase
   end

   // A pending target always wins over a same-cycle redirect; the bypass only
   // applies when nothing is pending
   always_comb begin
      w_imemReq = 1'b0;
      w_pcWe    = 1'b0;
      w_ifValid = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               w_imemReq = 1'b1;
               if (bus.imem_ack && !bus.stall) begin
                  w_pcWe    = 1'b1;
                  w_ifValid = 1'b1;
               end
            end
            S_HOLD: begin
               if (!bus.stall) begin
                  w_pcWe    = 1'b1;
                  w_ifValid = 1'b1;
               end
            end
            default: ;
         endcase
      end
      w_pcSel = NPC_PC4;
      if (w_pcWe) begin
         if (r_pendValid) begin
            w_pcSel = r_pendSel;
         end else if (w_accept) begin
            w_pcSel = w_mode;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pendValid <= 1'b0;
         r_pendSel   <= NPC_PC4;
         r_overlap   <= 1'b0;
      end else begin
         if (w_accept && r_pendValid) begin
            r_overlap <= 1'b1;
         end
         if (w_pcWe && r_pendValid) begin
            r_pendValid <= 1'b0;
         end else if (w_accept && !w_pcWe && !r_pendValid) begin
            r_pendValid <= 1'b1;
            r_pendSel   <= w_mode;
         end
      end
   end

   assign w_wdClear = (r_state != S_FETCH) | bus.imem_ack;
   assign w_wdInc   = (r_state == S_FETCH) & ~bus.imem_ack;

   ifu_fetch_sequencer_watchdog #(
      .WAIT_W   (WAIT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_wdClear),
      .i_inc     (w_wdInc),
      .o_timeout (w_timeout)
   );

   assign bus.imem_req         = w_imemReq;
   assign bus.pc_we            = w_pcWe;
   assign bus.pc_sel           = w_pcSel;
   assign bus.if_valid         = w_ifValid;
   assign bus.fetch_timeout    = w_timeout;
   assign bus.redirect_overlap = r_overlap;

endmodule

// File: tb/tb_ifu_fetch_sequencer.sv
// Directed bench for the fetch sequencer: inputs change 1ns after the rising
// edge and Mealy outputs are checked on the falling edge.
module tb_ifu_fetch_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;

   ifu_fetch_sequencer_if busIf ();

   ifu_fetch_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic rv, input logic [1:0] mode,
                                input logic isCond, input logic cond, input logic ack);
      busIf.stall          = st;
      busIf.redirect_valid = rv;
      busIf.npc_mode       = mode;
      busIf.is_conditional = isCond;
      busIf.condition      = cond;
      busIf.imem_ack       = ack;
   endtask

   // Checks one cycle's handshake outputs, then moves past the next rising edge
   task automatic expectCycle(input string tag, input int req, input int we,
                              input int sel, input int ifv);
      @(negedge clk);
      checkOutput({tag, ".req"}, int'(busIf.imem_req), req);
      checkOutput({tag, ".we"},  int'(busIf.pc_we),    we);
      checkOutput({tag, ".sel"}, int'(busIf.pc_sel),   sel);
      checkOutput({tag, ".ifv"}, int'(busIf.if_valid), ifv);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      expectCycle("rst", 0, 0, 0, 0);
      reset = 1'b0;

      expectCycle("boot", 0, 0, 0, 0);
      checkOutput("boot.timeout", int'(busIf.fetch_timeout), 0);
      checkOutput("boot.overlap", int'(busIf.redirect_overlap), 0);
      expectCycle("t1a", 1, 1, 0, 1);
      expectCycle("t1b", 1, 1, 0, 1);

      applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
      expectCycle("t2nt", 1, 1, 0, 1);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t2nopend", 1, 1, 0, 1);

      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      expectCycle("t3acc", 1, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      expectCycle("t3w1", 1, 0, 0, 0);
      expectCycle("t3w2", 1, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t3ack", 1, 1, 2, 1);
      expectCycle("t3clr", 1, 1, 0, 1);

      applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
      expectCycle("t4byp", 1, 1, 3, 1);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t4next", 1, 1, 0, 1);

      applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      expectCycle("t5mask", 1, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t5nopend", 1, 1, 0, 1);

      applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t5s1", 1, 0, 0, 0);
      expectCycle("t5s2", 0, 0, 0, 0);
      expectCycle("t5s3", 0, 0, 0, 0);
      expectCycle("t5s4", 0, 0, 0, 0);
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
      expectCycle("t5rel", 0, 1, 1, 1);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t5fetch", 1, 1, 0, 1);

      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         if (i == 2) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
         end else if (i == 3) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
         end
         @(negedge clk);
         checkOutput($sformatf("t6we%0d", i), int'(busIf.pc_we), 0);
         if (i == 2) checkOutput("t6overlap0", int'(busIf.redirect_overlap), 0);
         if (i == 3) checkOutput("t6overlap1", int'(busIf.redirect_overlap), 1);
         if (i == 15) checkOutput("t6timeout0", int'(busIf.fetch_timeout), 0);
         @(posedge clk);
         #1;
      end
      checkOutput("t6timeout1", int'(busIf.fetch_timeout), 1);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      expectCycle("t6ack", 1, 1, 2, 1);
      checkOutput("t6timeoutKeep", int'(busIf.fetch_timeout), 1);
      checkOutput("t6overlapKeep", int'(busIf.redirect_overlap), 1);

      applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      expectCycle("t6pend", 1, 0, 0, 0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("t6rstTimeout", int'(busIf.fetch_timeout), 0);
      checkOutput("t6rstOverlap", int'(busIf.redirect_overlap), 0);
      reset = 1'b0;
      expectCycle("t6boot", 0, 0, 0, 0);
      expectCycle("t6drop", 1, 1, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
